// File: rtl/relogio_ctrl.sv
// Button and mode sequencer for the relogio clock: conditions the raw buttons, runs the
// RUN/SET mode FSM, and issues adjust strobes with auto-repeat plus the field blink.
module relogio_ctrl #(
   parameter int unsigned DB_CYCLES     = 3,
   parameter int unsigned REPEAT_DELAY  = 64,
   parameter int unsigned REPEAT_PERIOD = 16,
   parameter int unsigned BLINK_HALF    = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       cont,
   input  logic       soma,
   input  logic       subtracao,
   output logic       run_en,
   output logic [1:0] field_sel,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       blink
);

   localparam int unsigned DbW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int unsigned RptW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
   localparam int unsigned BlkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   localparam int unsigned BtnStart = 0;
   localparam int unsigned BtnCont  = 1;
   localparam int unsigned BtnSoma  = 2;
   localparam int unsigned BtnSub   = 3;

   typedef enum logic [2:0] {StIdle, StRun, StSetH, StSetM, StSetS} state_e;

   logic [3:0]      raw;
   logic [3:0]      sync1_q, sync2_q;
   logic [3:0]      db_q, db_d, db_prev_q;
   logic [DbW-1:0]  db_cnt_q [4];
   logic [DbW-1:0]  db_cnt_d [4];
   logic [3:0]      press;

   state_e          state_q, state_d;
   logic            in_set_q, in_set_d, both_hi;
   logic            inc_q, inc_d, dec_q, dec_d;
   logic            arm_inc_q, arm_inc_d, arm_dec_q, arm_dec_d;
   logic [RptW-1:0] rpt_q, rpt_d;
   logic            blink_q, blink_d;
   logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;

   assign raw   = {subtracao, soma, cont, start};
   assign press = db_q & ~db_prev_q;

   // Debounced level flips only after DB_CYCLES consecutive samples disagree with it.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         db_d[i]     = db_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DbW'(DB_CYCLES - 1)) begin
               db_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   assign in_set_q = (state_q == StSetH) || (state_q == StSetM) || (state_q == StSetS);
   assign in_set_d = (state_d == StSetH) || (state_d == StSetM) || (state_d == StSetS);
   assign both_hi  = db_q[BtnSoma] & db_q[BtnSub];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (press[BtnStart]) state_d = StRun;
         StRun:   if (press[BtnCont])  state_d = StSetH;
         StSetH:  if (press[BtnCont])  state_d = StSetM;
         StSetM:  if (press[BtnCont])  state_d = StSetS;
         StSetS:  if (press[BtnCont])  state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // Strobes only from a fresh press or an armed repeat; any mode change disarms.
   always_comb begin
      inc_d     = 1'b0;
      dec_d     = 1'b0;
      arm_inc_d = arm_inc_q;
      arm_dec_d = arm_dec_q;
      rpt_d     = rpt_q;
      if (!in_set_q || press[BtnCont] || both_hi) begin
         arm_inc_d = 1'b0;
         arm_dec_d = 1'b0;
         rpt_d     = '0;
      end else if (press[BtnSoma]) begin
         inc_d     = 1'b1;
         arm_inc_d = 1'b1;
         arm_dec_d = 1'b0;
         rpt_d     = '0;
      end else if (press[BtnSub]) begin
         dec_d     = 1'b1;
         arm_inc_d = 1'b0;
         arm_dec_d = 1'b1;
         rpt_d     = '0;
      end else if ((arm_inc_q && db_q[BtnSoma]) || (arm_dec_q && db_q[BtnSub])) begin
         if (rpt_q == RptW'(REPEAT_DELAY - 1)) begin
            inc_d = arm_inc_q;
            dec_d = arm_dec_q;
            rpt_d = RptW'(REPEAT_DELAY - REPEAT_PERIOD);
         end else begin
            rpt_d = rpt_q + RptW'(1);
         end
      end else begin
         arm_inc_d = 1'b0;
         arm_dec_d = 1'b0;
         rpt_d     = '0;
      end
   end

   always_comb begin
      blink_d   = 1'b0;
      blk_cnt_d = '0;
      if (in_set_d && (state_d != state_q)) begin
         blink_d = 1'b1;
      end else if (in_set_d) begin
         if (blk_cnt_q == BlkW'(BLINK_HALF - 1)) begin
            blink_d = ~blink_q;
         end else begin
            blink_d   = blink_q;
            blk_cnt_d = blk_cnt_q + BlkW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
         state_q   <= StIdle;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
         arm_inc_q <= 1'b0;
         arm_dec_q <= 1'b0;
         rpt_q     <= '0;
         blink_q   <= 1'b0;
         blk_cnt_q <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
         state_q   <= state_d;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
         arm_inc_q <= arm_inc_d;
         arm_dec_q <= arm_dec_d;
         rpt_q     <= rpt_d;
         blink_q   <= blink_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   always_comb begin
      unique case (state_q)
         StSetH:  field_sel = 2'b01;
         StSetM:  field_sel = 2'b10;
         StSetS:  field_sel = 2'b11;
         default: field_sel = 2'b00;
      endcase
   end

   assign run_en    = (state_q == StRun);
   assign inc_pulse = inc_q;
   assign dec_pulse = dec_q;
   assign blink     = blink_q;

endmodule
